// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_WIDTH      = 32;
  localparam int unsigned DMEM_DEPTH_LOG2 = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [DMEM_WIDTH-1:0] addr;
    logic [DMEM_WIDTH-1:0] wdata;
  } dmem_cmd_t;

  // Any address bit at or above depth_log2 puts the word outside the array.
  function automatic logic addr_oor(input logic [DMEM_WIDTH-1:0] addr,
                                    input int unsigned depth_log2);
    return |(addr >> depth_log2);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master's request/response channel into the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic                  req;
  logic                  we;
  logic [DMEM_WIDTH-1:0] addr;
  logic [DMEM_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  ack;
  logic [DMEM_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, ack, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker; the port that did not win last takes a tie.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output logic [1:0] grant,
  output port_id_t   winner
);

  always_comb begin
    winner = PORT0;
    grant  = 2'b00;
    case (req)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      2'b11:   winner = ~last;
      default: winner = PORT0;
    endcase
    if (|req) begin
      grant = (winner == PORT1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-cycle access sequencer in front of the data memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DMEM_WIDTH-1:0] mem_addr,
  output logic [DMEM_WIDTH-1:0] mem_wdata,
  input  logic [DMEM_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t    state;
  port_id_t  last;
  port_id_t  owner;
  logic      we_q;
  logic      oor_q;

  logic [1:0] req_vec;
  logic [1:0] grant;
  port_id_t   winner;
  logic       xfer;
  dmem_cmd_t  sel_cmd;
  logic       sel_oor;

  assign req_vec = {m1.req, m0.req};

  rr_arb2 u_rr (
    .req    (req_vec),
    .last   (last),
    .grant  (grant),
    .winner (winner)
  );

  // Grants exist only while idle, so a request can never slip in mid-access.
  assign m0.gnt = (state == IDLE) & grant[0];
  assign m1.gnt = (state == IDLE) & grant[1];
  assign xfer   = (state == IDLE) & (|req_vec);
  assign busy   = (state == ACCESS);

  always_comb begin
    sel_cmd.we    = m0.we;
    sel_cmd.addr  = m0.addr;
    sel_cmd.wdata = m0.wdata;
    if (winner == PORT1) begin
      sel_cmd.we    = m1.we;
      sel_cmd.addr  = m1.addr;
      sel_cmd.wdata = m1.wdata;
    end
  end

  assign sel_oor = addr_oor(sel_cmd.addr, DEPTH_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= PORT1;
      owner     <= PORT0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0.ack    <= 1'b0;
      m0.err    <= 1'b0;
      m0.rdata  <= '0;
      m1.ack    <= 1'b0;
      m1.err    <= 1'b0;
      m1.rdata  <= '0;
    end else begin
      m0.ack <= 1'b0;
      m0.err <= 1'b0;
      m1.ack <= 1'b0;
      m1.err <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            state     <= ACCESS;
            last      <= winner;
            owner     <= winner;
            we_q      <= sel_cmd.we;
            oor_q     <= sel_oor;
            // Strobes are suppressed up front for out-of-range addresses.
            mem_read  <= ~sel_cmd.we & ~sel_oor;
            mem_write <= sel_cmd.we & ~sel_oor;
            mem_addr  <= sel_cmd.addr;
            mem_wdata <= sel_cmd.wdata;
          end
        end
        ACCESS: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          // Writes leave rdata untouched; out-of-range accesses return zero.
          if (owner == PORT0) begin
            m0.ack <= 1'b1;
            m0.err <= oor_q;
            if (oor_q) begin
              m0.rdata <= '0;
            end else if (!we_q) begin
              m0.rdata <= mem_rdata;
            end
          end else begin
            m1.ack <= 1'b1;
            m1.err <= oor_q;
            if (oor_q) begin
              m1.rdata <= '0;
            end else if (!we_q) begin
              m1.rdata <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0]  mem [512];
  logic [511:0] written = '0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as 0xA500_0000 | word index.
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[8:0]]     <= mem_wdata;
      written[mem_addr[8:0]] <= 1'b1;
    end
  end
  assign mem_rdata = written[mem_addr[8:0]] ? mem[mem_addr[8:0]]
                                            : (32'hA500_0000 | 32'(mem_addr[8:0]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
    end else begin
      m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
    end
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic even;

    // Reset values
    do_reset();
    #1;
    chk("rst_m0_gnt",   32'(m0_if.gnt),   32'h0);
    chk("rst_m1_gnt",   32'(m1_if.gnt),   32'h0);
    chk("rst_m0_ack",   32'(m0_if.ack),   32'h0);
    chk("rst_m1_ack",   32'(m1_if.ack),   32'h0);
    chk("rst_m0_err",   32'(m0_if.err),   32'h0);
    chk("rst_m1_err",   32'(m1_if.err),   32'h0);
    chk("rst_m0_rdata", m0_if.rdata,      32'h0);
    chk("rst_m1_rdata", m1_if.rdata,      32'h0);
    chk("rst_mem_rd",   32'(mem_read),    32'h0);
    chk("rst_mem_wr",   32'(mem_write),   32'h0);
    chk("rst_mem_addr", mem_addr,         32'h0);
    chk("rst_mem_wd",   mem_wdata,        32'h0);
    chk("rst_busy",     32'(busy),        32'h0);

    // Port 0 write then read back
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    #1;
    chk("wr_gnt0", 32'(m0_if.gnt), 32'h1);
    chk("wr_gnt1", 32'(m1_if.gnt), 32'h0);
    step();
    m0_if.req = 1'b0;
    chk("wr_busy",     32'(busy),      32'h1);
    chk("wr_strobe",   32'(mem_write), 32'h1);
    chk("wr_no_rd",    32'(mem_read),  32'h0);
    chk("wr_addr",     mem_addr,       32'd5);
    chk("wr_wdata",    mem_wdata,      32'hDEAD_BEEF);
    chk("wr_gnt_acc",  32'(m0_if.gnt), 32'h0);
    step();
    chk("wr_ack",      32'(m0_if.ack), 32'h1);
    chk("wr_err",      32'(m0_if.err), 32'h0);
    chk("wr_rdata",    m0_if.rdata,    32'h0);
    chk("wr_busy_off", 32'(busy),      32'h0);
    chk("wr_strobe_off", 32'(mem_write), 32'h0);
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    chk("rd_gnt0", 32'(m0_if.gnt), 32'h1);
    step();
    m0_if.req = 1'b0;
    chk("rd_strobe", 32'(mem_read),  32'h1);
    chk("rd_addr",   mem_addr,       32'd5);
    chk("rd_no_ack", 32'(m0_if.ack), 32'h0);
    step();
    chk("rd_ack",    32'(m0_if.ack), 32'h1);
    chk("rd_rdata",  m0_if.rdata,    32'hDEAD_BEEF);
    chk("rd_err",    32'(m0_if.err), 32'h0);
    step();
    chk("rd_ack_pulse", 32'(m0_if.ack), 32'h0);

    // Contention: both ports hold reads; grants alternate starting with m0
    do_reset();
    drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      even = (i % 2 == 0);
      #1;
      chk("ct_gnt0", 32'(m0_if.gnt), 32'(even));
      chk("ct_gnt1", 32'(m1_if.gnt), 32'(!even));
      step();
      chk("ct_busy",  32'(busy),     32'h1);
      chk("ct_rd",    32'(mem_read), 32'h1);
      chk("ct_addr",  mem_addr,      even ? 32'd1 : 32'd2);
      chk("ct_nogt0", 32'(m0_if.gnt), 32'h0);
      chk("ct_nogt1", 32'(m1_if.gnt), 32'h0);
      step();
      chk("ct_ack0", 32'(m0_if.ack), 32'(even));
      chk("ct_ack1", 32'(m1_if.ack), 32'(!even));
      if (even) chk("ct_rdata0", m0_if.rdata, 32'hA500_0001);
      else      chk("ct_rdata1", m1_if.rdata, 32'hA500_0002);
    end
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;

    // Out-of-range read on port 1
    drive(1, 1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    chk("oor_gnt1", 32'(m1_if.gnt), 32'h1);
    chk("oor_gnt0", 32'(m0_if.gnt), 32'h0);
    step();
    m1_if.req = 1'b0;
    chk("oor_no_rd", 32'(mem_read),  32'h0);
    chk("oor_no_wr", 32'(mem_write), 32'h0);
    chk("oor_busy",  32'(busy),      32'h1);
    step();
    chk("oor_ack",   32'(m1_if.ack), 32'h1);
    chk("oor_err",   32'(m1_if.err), 32'h1);
    chk("oor_rdata", m1_if.rdata,    32'h0);
    chk("oor_ack0",  32'(m0_if.ack), 32'h0);

    // Reset asserted during the ACCESS cycle of a write
    drive(0, 1'b1, 1'b1, 32'd7, 32'hCAFE_F00D);
    #1;
    chk("mr_gnt0", 32'(m0_if.gnt), 32'h1);
    step();
    m0_if.req = 1'b0;
    chk("mr_strobe", 32'(mem_write), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_wr_drop", 32'(mem_write), 32'h0);
    chk("mr_rd_drop", 32'(mem_read),  32'h0);
    chk("mr_busy",    32'(busy),      32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_ack0", 32'(m0_if.ack), 32'h0);
      chk("mr_no_ack1", 32'(m1_if.ack), 32'h0);
      chk("mr_idle",    32'(busy),      32'h0);
    end
    chk("mr_no_write", 32'(written[7]), 32'h0);

    // m1 pulses req while m0 owns ACCESS
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
    #1;
    chk("wd_gnt0", 32'(m0_if.gnt), 32'h1);
    step();
    m0_if.req = 1'b0;
    drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
    #1;
    chk("wd_gnt1_acc", 32'(m1_if.gnt), 32'h0);
    step();
    m1_if.req = 1'b0;
    chk("wd_ack0",  32'(m0_if.ack), 32'h1);
    chk("wd_rdata", m0_if.rdata,    32'hDEAD_BEEF);
    chk("wd_ack1",  32'(m1_if.ack), 32'h0);
    chk("wd_busy",  32'(busy),      32'h0);
    // last still points at m0, so m1 must take a tie
    drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
    #1;
    chk("wd_tie1", 32'(m1_if.gnt), 32'h1);
    chk("wd_tie0", 32'(m0_if.gnt), 32'h0);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    step();
    chk("wd_idle",    32'(busy),      32'h0);
    chk("wd_no_ack1", 32'(m1_if.ack), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
